// File: rtl/game_timer_pkg.sv
// Shared types and constants for the level countdown timer.
package game_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUNNING = 3'd1,
    ST_PAUSED  = 3'd2,
    ST_TIMEUP  = 3'd3,
    ST_TALLY   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int unsigned SECONDS_W   = 10;
  localparam int unsigned SECONDS_MAX = 999;

  localparam int unsigned DEF_TICKS_PER_SECOND  = 25_000_000;
  localparam int unsigned DEF_START_SECONDS     = 60;
  localparam int unsigned DEF_HURRY_SECONDS     = 10;
  localparam int unsigned DEF_TALLY_TICKS       = 250_000;
  localparam int unsigned DEF_POINTS_PER_SECOND = 50;
  localparam int unsigned DEF_BONUS_SECONDS     = 30;

  // Counter width able to hold the larger of the two terminal counts.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/game_timer_controller_tick_divider.sv
// Shared cycle divider: counts while enabled, emits a wrap pulse on the
// cycle the count equals the terminal value.
module tick_divider #(
  parameter int unsigned CNT_W = 25
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_terminal,
  output logic             o_wrap
);

  logic [CNT_W-1:0] r_count;

  assign o_wrap = i_en && (r_count == i_terminal);

  // Count register: clear wins, otherwise advance and wrap at terminal.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_wrap ? '0 : r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_timer_controller.sv
// Level countdown timer: start/pause/resume, hurry flag, time-up pulse and
// end-of-level tally of remaining seconds into score pulses.
// Optional: define GAME_TIMER_TIME_BONUS_EN to let add_time extend the clock.
module game_timer_controller
  import game_timer_pkg::*;
#(
  parameter int unsigned TICKS_PER_SECOND  = DEF_TICKS_PER_SECOND,
  parameter int unsigned START_SECONDS     = DEF_START_SECONDS,
  parameter int unsigned HURRY_SECONDS     = DEF_HURRY_SECONDS,
  parameter int unsigned TALLY_TICKS       = DEF_TALLY_TICKS,
  parameter int unsigned POINTS_PER_SECOND = DEF_POINTS_PER_SECOND,
  parameter int unsigned BONUS_SECONDS     = DEF_BONUS_SECONDS
) (
  input  logic                 vga_clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 level_clear,
  input  logic                 add_time,
  output logic [SECONDS_W-1:0] seconds,
  output logic                 hurry,
  output logic                 time_up,
  output logic                 points_valid,
  output logic [7:0]           points,
  output logic                 tally_done,
  output logic [2:0]           state_o
);

  localparam int unsigned CNT_W = cnt_width(TICKS_PER_SECOND, TALLY_TICKS);

  state_t               r_state, w_state_nxt;
  logic [SECONDS_W-1:0] r_seconds, w_seconds_nxt;
  logic                 r_time_up, w_time_up_nxt;
  logic                 r_points_valid, w_points_valid_nxt;
  logic                 r_tally_done, w_tally_done_nxt;
  logic                 w_run, w_en, w_clear, w_wrap, w_dec_run;
  logic [CNT_W-1:0]     w_terminal;
  logic [31:0]          w_sec_calc;

`ifndef GAME_TIMER_TIME_BONUS_EN
  logic w_unused_bonus;
  assign w_unused_bonus = add_time | (BONUS_SECONDS == 0);
`endif

  // Divider control: start > level_clear > pause > tick.
  assign w_run      = (r_state == ST_RUNNING) || (r_state == ST_PAUSED);
  assign w_en       = !start && ((w_run && !level_clear && !pause) ||
                                 ((r_state == ST_TALLY) && (r_seconds != '0)));
  assign w_clear    = start || (w_run && level_clear);
  assign w_terminal = (r_state == ST_TALLY) ? CNT_W'(TALLY_TICKS - 1)
                                            : CNT_W'(TICKS_PER_SECOND - 1);
  assign w_dec_run  = w_wrap && w_run && (r_seconds != '0);

  tick_divider #(.CNT_W(CNT_W)) u_tick (
    .i_clk      (vga_clock),
    .i_rst_n    (reset),
    .i_en       (w_en),
    .i_clear    (w_clear),
    .i_terminal (w_terminal),
    .o_wrap     (w_wrap)
  );

  // Next-state, next-seconds and pulse decode.
  always_comb begin
    w_state_nxt        = r_state;
    w_seconds_nxt      = r_seconds;
    w_time_up_nxt      = 1'b0;
    w_points_valid_nxt = 1'b0;
    w_tally_done_nxt   = 1'b0;
    w_sec_calc         = 32'(r_seconds);
    if (start) begin
      w_state_nxt   = ST_RUNNING;
      w_seconds_nxt = SECONDS_W'(START_SECONDS);
    end else begin
      case (r_state)
        ST_RUNNING, ST_PAUSED: begin
          if (level_clear) begin
            w_state_nxt = ST_TALLY;
          end else begin
            if (w_dec_run) w_sec_calc = w_sec_calc - 32'd1;
`ifdef GAME_TIMER_TIME_BONUS_EN
            if (add_time) begin
              w_sec_calc = w_sec_calc + 32'(BONUS_SECONDS);
              if (w_sec_calc > 32'(SECONDS_MAX)) w_sec_calc = 32'(SECONDS_MAX);
            end
`endif
            w_seconds_nxt = w_sec_calc[SECONDS_W-1:0];
            w_state_nxt   = pause ? ST_PAUSED : ST_RUNNING;
            if (w_dec_run && (w_sec_calc == 32'd0)) begin
              w_state_nxt   = ST_TIMEUP;
              w_time_up_nxt = 1'b1;
            end
          end
        end
        ST_TALLY: begin
          if (r_seconds == '0) begin
            w_state_nxt      = ST_DONE;
            w_tally_done_nxt = 1'b1;
          end else if (w_wrap) begin
            w_seconds_nxt      = r_seconds - SECONDS_W'(1);
            w_points_valid_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State, seconds and pulse registers.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_seconds      <= '0;
      r_time_up      <= 1'b0;
      r_points_valid <= 1'b0;
      r_tally_done   <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_seconds      <= w_seconds_nxt;
      r_time_up      <= w_time_up_nxt;
      r_points_valid <= w_points_valid_nxt;
      r_tally_done   <= w_tally_done_nxt;
    end
  end

  assign seconds      = r_seconds;
  assign hurry        = w_run && (r_seconds <= SECONDS_W'(HURRY_SECONDS)) && (r_seconds != '0);
  assign time_up      = r_time_up;
  assign points_valid = r_points_valid;
  assign points       = r_points_valid ? 8'(POINTS_PER_SECOND) : 8'd0;
  assign tally_done   = r_tally_done;
  assign state_o      = r_state;

endmodule
